// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Issue-stage hazard controller for an 8-register core.
//                - Per-register scoreboard of in-flight long-latency writes
//                  (load/mul). Issue stalls on RAW/WAW hazards against it.
//                - 2-deep destination shift pipeline for single-cycle ALU
//                  results. It drives the operand forwarding mux selects.
//                - Caps the number of outstanding long ops.
//                - Raises a sticky flag when a stall lasts too long.
//  Ports       :
//    clk_i            clock
//    rst_i            synchronous, active-high reset
//    issue_valid_i    decode presents an instruction
//    issue_wr_en_i    instruction writes rd
//    issue_long_i     instruction is long-latency (result via wb port)
//    issue_rd_addr_i  destination register
//    rs1_addr_i       source 1 address      rs1_used_i  source 1 is read
//    rs2_addr_i       source 2 address      rs2_used_i  source 2 is read
//    wb_valid_i       long-latency result writes back this cycle
//    wb_rd_addr_i     long-latency result destination
//    flush_i          squash younger short ops (branch redirect)
//    stall_o          hold decode/issue this cycle
//    forward_a_o      rs1 select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 wb bus
//    forward_b_o      rs2 select, same encoding
//    busy_o           scoreboard pending bits
//    hang_o           sticky stall-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int HANG_CYCLES     = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_valid_i,
  input  logic       issue_wr_en_i,
  input  logic       issue_long_i,
  input  logic [2:0] issue_rd_addr_i,
  input  logic [2:0] rs1_addr_i,
  input  logic [2:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic       wb_valid_i,
  input  logic [2:0] wb_rd_addr_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o,
  output logic [7:0] busy_o,
  output logic       hang_o
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int HANG_W = $clog2(HANG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  c_max_out  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [HANG_W-1:0] c_hang_max = HANG_W'(HANG_CYCLES);

  localparam logic [1:0] c_fwd_rf  = 2'b00;
  localparam logic [1:0] c_fwd_s1  = 2'b10;
  localparam logic [1:0] c_fwd_s2  = 2'b01;
  localparam logic [1:0] c_fwd_wb  = 2'b11;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]        r_pend;
  logic [CNT_W-1:0]  r_count;
  logic              r_s1_valid;
  logic [2:0]        r_s1_rd;
  logic              r_s2_valid;
  logic [2:0]        r_s2_rd;
  logic [HANG_W-1:0] r_hang_cnt;
  logic              r_hang;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic w_wbhit_rs1;
  logic w_wbhit_rs2;
  logic w_wbhit_rd;
  logic w_raw1;
  logic w_raw2;
  logic w_waw;
  logic w_cap;
  logic w_stall;
  logic w_accept;

  // A writeback landing this cycle resolves the hazard: its value is on the
  // wb bus and can be forwarded directly.
  assign w_wbhit_rs1 = wb_valid_i && (wb_rd_addr_i == rs1_addr_i);
  assign w_wbhit_rs2 = wb_valid_i && (wb_rd_addr_i == rs2_addr_i);
  assign w_wbhit_rd  = wb_valid_i && (wb_rd_addr_i == issue_rd_addr_i);

  assign w_raw1 = rs1_used_i && r_pend[rs1_addr_i] && !w_wbhit_rs1;
  assign w_raw2 = rs2_used_i && r_pend[rs2_addr_i] && !w_wbhit_rs2;
  assign w_waw  = issue_wr_en_i && (issue_rd_addr_i != 3'd0) &&
                  r_pend[issue_rd_addr_i] && !w_wbhit_rd;
  // A writeback frees a slot in the same cycle, so a full tracker does not
  // block a new long op while one retires.
  assign w_cap  = issue_long_i && (r_count == c_max_out) && !wb_valid_i;

  assign w_stall  = issue_valid_i && (w_raw1 || w_raw2 || w_waw || w_cap);
  assign w_accept = issue_valid_i && !w_stall;

  // --------------------------------------------------------------------------
  // Long-op scoreboard
  // --------------------------------------------------------------------------
  logic       w_set_pend;
  logic [7:0] w_pend_nxt;

  assign w_set_pend = w_accept && issue_wr_en_i && issue_long_i &&
                      (issue_rd_addr_i != 3'd0);

  // Set is applied after clear so a same-cycle set/clear of one register
  // leaves it pending (the new producer is still in flight).
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_valid_i) begin
      w_pend_nxt[wb_rd_addr_i] = 1'b0;
    end
    if (w_set_pend) begin
      w_pend_nxt[issue_rd_addr_i] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Outstanding long-op counter
  // --------------------------------------------------------------------------
  logic             w_cnt_inc;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_cnt_inc = w_accept && issue_long_i;
  // A stray writeback with nothing outstanding (e.g. one that was already in
  // flight across a reset) must not wrap the counter.
  assign w_cnt_dec = wb_valid_i && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_cnt_inc, w_cnt_dec})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Short-op destination pipeline
  // --------------------------------------------------------------------------
  logic w_capture_s1;

  assign w_capture_s1 = w_accept && issue_wr_en_i && !issue_long_i &&
                        (issue_rd_addr_i != 3'd0);

  // --------------------------------------------------------------------------
  // Stall timeout
  // --------------------------------------------------------------------------
  logic [HANG_W-1:0] w_hang_cnt_nxt;

  // Saturates so a very long stall cannot wrap and mask the condition.
  always_comb begin
    w_hang_cnt_nxt = '0;
    if (w_stall) begin
      if (r_hang_cnt == c_hang_max) begin
        w_hang_cnt_nxt = r_hang_cnt;
      end else begin
        w_hang_cnt_nxt = r_hang_cnt + HANG_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend     <= '0;
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_rd    <= 3'd0;
      r_s2_valid <= 1'b0;
      r_s2_rd    <= 3'd0;
      r_hang_cnt <= '0;
      r_hang     <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_count    <= w_count_nxt;
      r_hang_cnt <= w_hang_cnt_nxt;
      if (w_hang_cnt_nxt == c_hang_max) begin
        r_hang <= 1'b1;
      end

      // Flush squashes both short stages and wins over a new capture.
      if (flush_i) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_capture_s1;
        r_s2_valid <= r_s1_valid;
      end
      if (w_capture_s1) begin
        r_s1_rd <= issue_rd_addr_i;
      end
      r_s2_rd <= r_s1_rd;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding selects
  // --------------------------------------------------------------------------
  // Youngest value wins: wb bus, then EX/MEM, then MEM/WB. x0 is hardwired
  // and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [2:0] rs,
    input logic       wbhit,
    input logic       s1_valid,
    input logic [2:0] s1_rd,
    input logic       s2_valid,
    input logic [2:0] s2_rd
  );
    logic [1:0] sel;
    sel = c_fwd_rf;
    if (rs != 3'd0) begin
      if (wbhit) begin
        sel = c_fwd_wb;
      end else if (s1_valid && (s1_rd == rs)) begin
        sel = c_fwd_s1;
      end else if (s2_valid && (s2_rd == rs)) begin
        sel = c_fwd_s2;
      end
    end
    return sel;
  endfunction

  assign forward_a_o = fwd_sel(rs1_addr_i, w_wbhit_rs1, r_s1_valid, r_s1_rd,
                               r_s2_valid, r_s2_rd);
  assign forward_b_o = fwd_sel(rs2_addr_i, w_wbhit_rs2, r_s1_valid, r_s1_rd,
                               r_s2_valid, r_s2_rd);

  assign stall_o = w_stall;
  assign busy_o  = r_pend;
  assign hang_o  = r_hang;

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-stage hazard controller for the 8-register (3-bit address) core.
- Tracks in-flight long-latency writes (load/mul) in a per-register scoreboard and stalls issue on RAW/WAW hazards against them.
- Sequences operand forwarding for single-cycle ALU results via a 2-deep destination shift pipeline; caps outstanding long ops and flags stuck stalls.
- Sits between decode and the execute stage; drives the operand-mux selects.

Parameters:
- MAX_OUTSTANDING, 2, maximum long-latency ops in flight (1..7)
- HANG_CYCLES, 64, consecutive stall cycles before hang_o asserts

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- issue_valid_i  input  1  decode presents an instruction
- issue_wr_en_i  input  1  instruction writes rd
- issue_long_i  input  1  instruction is long-latency (result via wb port)
- issue_rd_addr_i  input  3  destination register
- rs1_addr_i  input  3  source 1
- rs2_addr_i  input  3  source 2
- rs1_used_i  input  1  rs1 is read
- rs2_used_i  input  1  rs2 is read
- wb_valid_i  input  1  long-latency result writes back this cycle
- wb_rd_addr_i  input  3  long-latency result destination
- flush_i  input  1  squash younger short ops (branch redirect)
- stall_o  output  1  hold decode/issue this cycle
- forward_a_o  output  2  rs1 select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 wb bus
- forward_b_o  output  2  rs2 select, same encoding
- busy_o  output  8  scoreboard pending bits
- hang_o  output  1  sticky stall-timeout flag

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: pend=0, outstanding count=0, s1/s2 stages invalid, stall counter=0, hang_o=0; so stall_o=0, forward_*=00, busy_o=0.
- Accept = issue_valid_i && !stall_o.
- Long-op scoreboard: pend[rd] sets on accept with wr_en && long && rd!=0; pend[wb_rd] clears on wb_valid_i. Same-cycle set and clear of the same reg -> remains 1. pend[0] is always 0.
- Outstanding count: +1 on accepted long op, -1 on wb_valid_i, unchanged if both. Width holds 0..MAX_OUTSTANDING. wb_valid_i at count 0 is ignored (no underflow).
- Let wbhit(r) = wb_valid_i && wb_rd_addr_i==r. stall_o is combinational and asserts when issue_valid_i and any of:
  - rs1_used && pend[rs1] && !wbhit(rs1) (likewise rs2);
  - wr_en && rd!=0 && pend[rd] && !wbhit(rd) (WAW);
  - long && count==MAX_OUTSTANDING && !wb_valid_i.
- Short pipeline: s1 captures {rd, wen} of accepted short writes (rd!=0). Otherwise s1 gets a bubble, including on stall or a long op. s2<=s1 every cycle. flush_i invalidates s1 and s2 next cycle and has priority over capture. flush_i does not touch pend or count.
- Forward select per source, combinational, priority: wbhit -> 11; s1 valid && s1.rd==rs -> 10; s2 valid && s2.rd==rs -> 01; else 00. rs==0 always yields 00.
- Hang: counter increments while stall_o, clears when !stall_o. Reaching HANG_CYCLES sets hang_o, which clears only on rst_i.
- Reset mid-operation: all state cleared next edge; in-flight wb_valid_i after reset is ignored (count 0).

Test Plan:
- Back-to-back ALU: write x3 accepted, next cycle rs1=x3 -> forward_a_o=10; one gap cycle -> 01; two gaps -> 00.
- Load-use: long write x5 accepted, next issue rs2=x5 -> stall_o=1 until the wb_valid_i/x5 cycle. In that cycle stall_o=0, forward_b_o=11, busy_o[5] falls next edge.
- Capacity: MAX_OUTSTANDING=2, two long ops to x1,x2 accepted, third long op -> stall_o=1. Same cycle as wb_valid_i -> accepted, count stays 2.
- WAW and x0: pend[4]=1, issue short write x4 -> stall. Issue long write x0 -> no pend bit set, stall_o=0, busy_o=0.
- Flush: short write x6 accepted, flush_i next cycle, then rs1=x6 -> forward_a_o=00. pend bits and count are preserved.
- Hang/reset: hold pend[7] with rs1=x7 and no writeback for 64 cycles -> hang_o=1 and stays high. Assert rst_i -> all outputs 0 next edge.
